multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles waiting for any memory ack before error.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 imem_req_o  out  1  instruction fetch request, held until ack.
REQ-005 imem_ack_i  in  1  instruction word valid this cycle.
REQ-006 ir_load_o  out  1  load instruction register (one-cycle pulse).
REQ-007 dec_ctrl_i  in  6  decoded flags {reg_write, branch, jump, jalr, mem_read, mem_write}, valid from DECODE onward.
REQ-008 br_taken_i  in  1  branch comparison result, valid in EXEC.
REQ-009 dmem_req_o  out  1  data memory request, held until ack.
REQ-010 dmem_we_o  out  1  data request is a store; valid while dmem_req_o high.
REQ-011 dmem_ack_i  in  1  data access complete (load data valid) this cycle.
REQ-012 pc_write_o  out  1  update PC (one-cycle pulse per instruction).
REQ-013 pc_src_o  out  2  PC source: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
REQ-014 rf_we_o  out  1  register file write enable (one-cycle pulse).
REQ-015 wb_sel_o  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-016 state_o  out  3  current state encoding.
REQ-017 bus_err_o  out  1  sticky memory-timeout error.

Function
REQ-018 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs registered-state Moore except where stated.
REQ-019 FETCH: imem_req_o=1; on imem_ack_i, ir_load_o=1 same cycle (Mealy), next DECODE.
REQ-020 DECODE: one cycle, no outputs asserted, next EXEC.
REQ-021 EXEC: one cycle; mem_read or mem_write -> MEM; else -> WB.
REQ-022 EXEC with branch: pc_write_o=br_taken_i, pc_src_o=01; branch with no reg_write SHALL go to FETCH, skipping WB.
REQ-023 MEM: dmem_req_o=1, dmem_we_o=mem_write; on dmem_ack_i: store -> next FETCH with pc_write_o=1, pc_src_o=00; load -> next WB.
REQ-024 WB: rf_we_o=reg_write, pc_write_o=1; wb_sel_o=01 for load, 10 for jump/jalr, else 00; pc_src_o=10 if jalr, 01 if jump, else 00; next FETCH.
REQ-025 Non-taken branch SHALL pulse pc_write_o with pc_src_o=00 in EXEC; exactly one pc_write_o pulse per retired instruction.
REQ-026 dec_ctrl_i all-zero (unsupported opcode) SHALL traverse EXEC->WB with rf_we_o=0, PC+4.
REQ-027 Wait counter SHALL reset on entering FETCH or MEM, count each cycle without ack; reaching TIMEOUT -> HALT, bus_err_o=1, request dropped.
REQ-028 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL be honoured (ack wins).
REQ-029 HALT: all request/enable outputs 0; left only by reset.
REQ-030 Acks outside the matching request state SHALL be ignored.

Reset
REQ-031 rst_i high at a clock edge SHALL force FETCH, counter 0, bus_err_o=0, from any state incl. mid-MEM.
REQ-032 During and after reset edge all pulse outputs, requests, dmem_we_o=0; pc_src_o=00, wb_sel_o=00; state_o=FETCH encoding.
REQ-033 First imem_req_o SHALL assert the cycle after rst_i deasserts.

Structure
REQ-034 State encoding, pc_src and wb_sel codes, dec_ctrl_i bit indices SHALL live in shared package core_ctrl_pkg.
REQ-035 Wait counter SHALL be sub-module mem_wait_timer (TIMEOUT parameter, clear/count in, expired out).

Verification
REQ-036 ADD, imem ack after 1 cycle -> states FETCH,FETCH,DECODE,EXEC,WB; rf_we_o=1, wb_sel_o=00, pc_src_o=00 in WB.
REQ-037 LW, dmem ack after 3 cycles -> dmem_req_o high 4 cycles, dmem_we_o=0, then WB with wb_sel_o=01, rf_we_o=1.
REQ-038 SW, immediate ack -> dmem_we_o=1, rf_we_o never 1, pc_write_o=1/pc_src_o=00 in ack cycle.
REQ-039 BEQ taken then not taken -> EXEC pc_write_o=1, pc_src_o=01 then pc_src_o=00; no WB visit.
REQ-040 JALR -> WB rf_we_o=1, wb_sel_o=10, pc_src_o=10; JAL -> pc_src_o=01.
REQ-041 TIMEOUT=4, no imem ack -> HALT, bus_err_o=1 after 4 cycles; rst_i pulse -> FETCH, bus_err_o=0; rst_i mid-MEM -> dmem_req_o=0 next cycle.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM.
// State encodings, PC/writeback select codes, decoded-flag bit positions.
package core_ctrl_pkg;

    // FSM state encodings (3-bit, exported on state_o)
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // PC source select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Bit positions inside dec_ctrl_i
    localparam int DC_W         = 6;
    localparam int DC_REG_WRITE = 5;
    localparam int DC_BRANCH    = 4;
    localparam int DC_JUMP      = 3;
    localparam int DC_JALR      = 2;
    localparam int DC_MEM_READ  = 1;
    localparam int DC_MEM_WRITE = 0;

    typedef struct packed {
        logic reg_write;
        logic branch;
        logic jump;
        logic jalr;
        logic mem_read;
        logic mem_write;
    } dec_ctrl_t;

    function automatic logic is_mem_op(input dec_ctrl_t dc);
        return dc.mem_read | dc.mem_write;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without an ack.
// Ports: clk_i, rst_i, clear_i (restart), count_i (waiting, no ack), expired_o.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Expires in the cycle that would bring the count to TIMEOUT;
    // an ack in that cycle drops count_i, so the ack wins.
    assign expired_o = count_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Ports: imem/dmem handshakes, decoded flags in, PC/RF/IR controls, state_o, bus_err_o.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        ir_load_o,
    input  logic [5:0]  dec_ctrl_i,
    input  logic        br_taken_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        bus_err_o
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       bus_err_q;
    logic       bus_err_d;

    dec_ctrl_t  dc;
    logic       wait_st;
    logic       ack_st;
    logic       tmr_clear;
    logic       tmr_count;
    logic       tmr_expired;

    assign dc = dec_ctrl_t'(dec_ctrl_i);

    // Only the ack matching the current request state is seen
    always_comb begin
        wait_st = 1'b0;
        ack_st  = 1'b0;
        if (state_q == ST_FETCH) begin
            wait_st = 1'b1;
            ack_st  = imem_ack_i;
        end else if (state_q == ST_MEM) begin
            wait_st = 1'b1;
            ack_st  = dmem_ack_i;
        end
    end

    // Held at zero outside FETCH/MEM so each entry starts from 0
    assign tmr_clear = !wait_st || ack_st;
    assign tmr_count = wait_st && !ack_st;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (tmr_clear),
        .count_i   (tmr_count),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack_i) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                // Branch resolves PC here; WB only if it also writes a reg
                if (dc.branch) begin
                    state_d = dc.reg_write ? ST_WB : ST_FETCH;
                end else if (is_mem_op(dc)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack_i) begin
                    state_d = dc.mem_write ? ST_FETCH : ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus_err_d = bus_err_q | tmr_expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Output decode; everything is forced quiet while rst_i is high
    always_comb begin
        imem_req_o = 1'b0;
        ir_load_o  = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        pc_write_o = 1'b0;
        pc_src_o   = PC_PLUS4;
        rf_we_o    = 1'b0;
        wb_sel_o   = WB_ALU;
        if (!rst_i) begin
            unique case (state_q)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_load_o  = imem_ack_i;
                end
                ST_EXEC: begin
                    // Taken or not, a branch retires its PC update here
                    if (dc.branch) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = br_taken_i ? PC_IMM : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = dc.mem_write;
                    if (dmem_ack_i && dc.mem_write) begin
                        pc_write_o = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we_o    = dc.reg_write;
                    pc_write_o = !dc.branch;
                    if (dc.mem_read) begin
                        wb_sel_o = WB_MEM;
                    end else if (dc.jump || dc.jalr) begin
                        wb_sel_o = WB_PC4;
                    end
                    if (dc.jalr) begin
                        pc_src_o = PC_JALR;
                    end else if (dc.jump) begin
                        pc_src_o = PC_IMM;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o   = state_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level check of multicycle_ctrl.
// Expected per-cycle outputs are derived from the instruction flow rules.
module tb_multicycle_ctrl;
    import core_ctrl_pkg::*;

    localparam int TO = 4;

    logic       clk;
    logic       rst_i;
    logic       imem_req_o;
    logic       imem_ack_i;
    logic       ir_load_o;
    logic [5:0] dec_ctrl_i;
    logic       br_taken_i;
    logic       dmem_req_o;
    logic       dmem_we_o;
    logic       dmem_ack_i;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       rf_we_o;
    logic [1:0] wb_sel_o;
    logic [2:0] state_o;
    logic       bus_err_o;

    int checks = 0;
    int failures = 0;
    int pcw_cnt = 0;

    multicycle_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .imem_req_o (imem_req_o),
        .imem_ack_i (imem_ack_i),
        .ir_load_o  (ir_load_o),
        .dec_ctrl_i (dec_ctrl_i),
        .br_taken_i (br_taken_i),
        .dmem_req_o (dmem_req_o),
        .dmem_we_o  (dmem_we_o),
        .dmem_ack_i (dmem_ack_i),
        .pc_write_o (pc_write_o),
        .pc_src_o   (pc_src_o),
        .rf_we_o    (rf_we_o),
        .wb_sel_o   (wb_sel_o),
        .state_o    (state_o),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ev(
        input logic [2:0] st, input logic ireq, input logic irl,
        input logic dreq, input logic dwe, input logic pcw,
        input logic [1:0] pcs, input logic rfwe,
        input logic [1:0] wbs, input logic err);
        return {st, ireq, irl, dreq, dwe, pcw, pcs, rfwe, wbs, err, 2'b00};
    endfunction

    // One cycle: inputs already set; sample mid-cycle, then advance
    task automatic tick(input string tag, input logic [15:0] exp,
                        input logic [15:0] mask = 16'hFFFF);
        logic [15:0] got;
        @(negedge clk);
        got = {state_o, imem_req_o, ir_load_o, dmem_req_o, dmem_we_o,
               pc_write_o, pc_src_o, rf_we_o, wb_sel_o, bus_err_o, 2'b00};
        pcw_cnt += int'(pc_write_o);
        check(tag, got & mask, exp & mask);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        imem_ack_i = 1'($urandom);
        dmem_ack_i = 1'($urandom);
        br_taken_i = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        noise();
        // Before the edge the old state is still visible; controls must be 0
        tick("rst_quiet", 16'h0000, 16'h1FF8);
        rst_i = 1'b1;
        noise();
        tick("rst_state", ev(ST_FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        rst_i = 1'b0;
    endtask

    task automatic halt_check();
        for (int i = 0; i < 3; i++) begin
            noise();
            dec_ctrl_i = 6'($urandom);
            tick("halt", ev(ST_HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        end
    endtask

    // Runs one instruction; idl/ddl are ack delays (>=TO means no ack),
    // mrst is the MEM cycle index at which reset is applied (-1 none).
    task automatic run_instr(input logic [5:0] ctl, input logic tk,
                             input int idl, input int ddl, input int mrst);
        logic rw, br, j, jr, mr, mw;
        logic [1:0] wbs;
        logic [1:0] pcs;
        {rw, br, j, jr, mr, mw} = ctl;
        pcw_cnt = 0;
        for (int k = 0; k <= idl && k < TO; k++) begin
            noise();
            imem_ack_i = (k == idl);
            dec_ctrl_i = 6'($urandom);
            tick("fetch", ev(ST_FETCH, 1, k == idl, 0, 0, 0,
                             2'b00, 0, 2'b00, 0));
        end
        if (idl >= TO) begin
            halt_check();
            do_reset();
            return;
        end
        dec_ctrl_i = ctl;
        noise();
        tick("decode", ev(ST_DECODE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        noise();
        br_taken_i = tk;
        if (br) begin
            tick("exec_br", ev(ST_EXEC, 0, 0, 0, 0, 1,
                               tk ? 2'b01 : 2'b00, 0, 2'b00, 0));
        end else begin
            tick("exec", ev(ST_EXEC, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
        end
        if (br && !rw) begin
            check("pcw_once", 16'(pcw_cnt), 16'd1);
            return;
        end
        if (!br && (mr || mw)) begin
            for (int k = 0; k <= ddl && k < TO; k++) begin
                if (k == mrst) begin
                    dmem_ack_i = 1'b0;
                    do_reset();
                    return;
                end
                noise();
                dmem_ack_i = (k == ddl);
                tick("mem", ev(ST_MEM, 0, 0, 1, mw, (k == ddl) && mw,
                               2'b00, 0, 2'b00, 0));
            end
            if (ddl >= TO) begin
                halt_check();
                do_reset();
                return;
            end
            if (mw) begin
                check("pcw_once", 16'(pcw_cnt), 16'd1);
                return;
            end
        end
        wbs = mr ? 2'b01 : ((j || jr) ? 2'b10 : 2'b00);
        pcs = jr ? 2'b10 : (j ? 2'b01 : 2'b00);
        noise();
        tick("wb", ev(ST_WB, 0, 0, 0, 0, !br, pcs, rw, wbs, 0));
        check("pcw_once", 16'(pcw_cnt), 16'd1);
    endtask

    localparam logic [5:0] I_ADD  = 6'b100000;
    localparam logic [5:0] I_LW   = 6'b100010;
    localparam logic [5:0] I_SW   = 6'b000001;
    localparam logic [5:0] I_BEQ  = 6'b010000;
    localparam logic [5:0] I_JAL  = 6'b101000;
    localparam logic [5:0] I_JALR = 6'b100100;
    localparam logic [5:0] I_NONE = 6'b000000;

    logic [5:0] itab [7];

    initial begin
        itab[0] = I_ADD;
        itab[1] = I_LW;
        itab[2] = I_SW;
        itab[3] = I_BEQ;
        itab[4] = I_JAL;
        itab[5] = I_JALR;
        itab[6] = I_NONE;

        rst_i      = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        dec_ctrl_i = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(I_ADD, 0, 1, 0, -1);
        run_instr(I_LW, 0, 0, 3, -1);
        run_instr(I_SW, 0, 0, 0, -1);
        run_instr(I_BEQ, 1, 0, 0, -1);
        run_instr(I_BEQ, 0, 2, 0, -1);
        run_instr(I_JALR, 0, 0, 0, -1);
        run_instr(I_JAL, 0, 0, 0, -1);
        run_instr(I_NONE, 1, 0, 0, -1);
        run_instr(I_ADD, 0, TO - 1, 0, -1);
        run_instr(I_LW, 0, 0, TO - 1, -1);
        run_instr(I_ADD, 0, TO, 0, -1);
        run_instr(I_LW, 0, 0, 3, 2);
        run_instr(I_SW, 0, 1, TO, -1);

        for (int n = 0; n < 120; n++) begin
            logic [5:0] ctl;
            int idl;
            int ddl;
            int mr;
            ctl = itab[$urandom_range(0, 6)];
            idl = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
            ddl = ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
            mr  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 2) : -1;
            run_instr(ctl, 1'($urandom), idl, ddl, mr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
